// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue: LANES-wide in-order Fetch->Decode buffer; entries visible the cycle after push, or same cycle when empty with FETCH_ISSUE_QUEUE_BYPASS_EN.
// Backpressure: in_ready drops unless LANES slots are free (registered count only); Decode pops 0..LANES per cycle via out_take.
module fetch_issue_queue #(
   parameter int LANES  = 2,
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [LANES-1:0]              in_valid,
   input  logic [LANES*DATA_W-1:0]       in_instr,
   input  logic [LANES*DATA_W-1:0]       in_pcplus4,
   output logic                          in_ready,
   output logic [LANES-1:0]              out_valid,
   output logic [LANES*DATA_W-1:0]       out_instr,
   output logic [LANES*DATA_W-1:0]       out_pcplus4,
   input  logic [$clog2(LANES+1)-1:0]    out_take,
   output logic                          take_err,
   output logic [$clog2(DEPTH+1)-1:0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [DATA_W-1:0] mem_instr [DEPTH];
   logic [DATA_W-1:0] mem_pc    [DEPTH];

   logic [CW-1:0] pushed;
   logic [CW-1:0] popped;
   logic [CW-1:0] skip;
   logic [CW-1:0] stored;
   logic [CW-1:0] take_w;
   logic [CW-1:0] avail;
   logic          byp;

   assign in_ready = (count <= CW'(DEPTH - LANES));
   assign take_w   = CW'(out_take);

`ifdef FETCH_ISSUE_QUEUE_BYPASS_EN
   assign byp = (count == '0) && !flush;
`else
   assign byp = 1'b0;
`endif

   always_comb begin
      pushed = '0;
      for (int i = 0; i < LANES; i++) begin
         if (in_ready && in_valid[i]) pushed = pushed + CW'(1);
      end
   end

   // In bypass, lanes Decode takes straight from Fetch are never stored.
   assign avail  = byp ? pushed : count;
   assign skip   = byp ? ((take_w < pushed) ? take_w : pushed) : '0;
   assign popped = byp ? '0 : ((take_w < count) ? take_w : count);
   assign stored = pushed - skip;

   always_comb begin
      out_valid   = '0;
      out_instr   = '0;
      out_pcplus4 = '0;
      for (int i = 0; i < LANES; i++) begin
         if (byp) begin
            if (in_valid[i] && in_ready) begin
               out_valid[i]                    = 1'b1;
               out_instr[i*DATA_W +: DATA_W]   = in_instr[i*DATA_W +: DATA_W];
               out_pcplus4[i*DATA_W +: DATA_W] = in_pcplus4[i*DATA_W +: DATA_W];
            end
         end else if (count > CW'(i)) begin
            out_valid[i]                    = 1'b1;
            out_instr[i*DATA_W +: DATA_W]   = mem_instr[head + PW'(i)];
            out_pcplus4[i*DATA_W +: DATA_W] = mem_pc[head + PW'(i)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         take_err <= 1'b0;
      end else if (flush) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         take_err <= 1'b0;
      end else begin
         head     <= head + popped[PW-1:0];
         tail     <= tail + stored[PW-1:0];
         count    <= count + stored - popped;
         take_err <= (take_w > avail);
      end
   end

   // Storage is never reset; out_valid gating keeps stale entries hidden.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (reset && !flush && in_ready && in_valid[i] && (CW'(i) >= skip)) begin
            mem_instr[tail + PW'(i) - skip[PW-1:0]] <= in_instr[i*DATA_W +: DATA_W];
            mem_pc[tail + PW'(i) - skip[PW-1:0]]    <= in_pcplus4[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule
